tipi_shift_seq: RTL
===================

// Module: tipi_shift_seq
// PURPOSE
//  Pi-side master sequencer for the TIPI serial register link. Turns a single
//  byte request (write RD/RC, or read TD/TC) into the r_clk/r_le/r_rt/r_cd/
//  r_dout pin sequence that the CPLD shift registers expect, and returns the
//  read byte. Used as a hardware stand-in for the RPi GPIO driver on test rigs.
// PARAMETERS
//  HALF_DIV  4  clk cycles per r_clk half-period (legal 1..255)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  r_reset    in   1  asynchronous, active-low reset
//  req_valid  in   1  request present
//  req_ready  out  1  sequencer idle; request accepted when valid&ready
//  req_write  in   1  1 = write RD/RC (Pi->TI), 0 = read TD/TC (TI->Pi)
//  req_ctrl   in   1  1 = control reg (RC/TC), 0 = data reg (RD/TD)
//  req_data   in   8  byte to write, [7] shifted first
//  rsp_valid  out  1  one-cycle pulse, transfer complete
//  rsp_data   out  8  read byte (0x00 for writes), held until next rsp_valid
//  rsp_perr   out  1  parity mismatch on write (see CONFIGURATION)
//  r_clk      out  1  link shift clock, idles low
//  r_rt       out  1  1 = TI-originated reg (TD/TC), 0 = Pi reg (RD/RC)
//  r_cd       out  1  1 = data reg, 0 = control reg
//  r_le       out  1  load/latch enable
//  r_dout     out  1  serial data to CPLD
//  r_din      in   1  serial data from CPLD (registered on r_clk rise in CPLD)
// BEHAVIOUR
//  Reset: req_ready=1, rsp_valid=0, rsp_data=0x00, rsp_perr=0, r_clk=0,
//   r_le=0, r_dout=0, r_rt=0, r_cd=1; state IDLE, counters 0.
//  Accept: on valid&ready latch write/ctrl/data; r_rt=~req_write,
//   r_cd=~req_ctrl; req_ready drops next cycle. r_rt/r_cd stable whole transfer.
//  States: IDLE -> SETUP (1 half-period, r_clk low) -> HI -> LO -> ... -> DONE
//   -> IDLE. HI/LO each last HALF_DIV clk; pulse counter pc (4b) incr on LO exit.
//  Pins change only on entry to LO or SETUP (never while r_clk high).
//  Write (N=9 pulses): pulses 0..7 r_le=0, r_dout=data[7-pc]; pulse 8 r_le=1
//   (latch to parallel out), r_dout=0.
//  Read (N=10 pulses): pulse 0 r_le=1 (parallel load); pulses 1..9 r_le=0.
//   CPLD output is registered, so bit data[7-k] sampled from r_din on last clk
//   of LO phase preceding pulse k+2, k=0..7; shifted into rsp shift reg MSB first.
//  After pulse N-1 LO phase: DONE for 1 clk: rsp_valid=1, rsp_data updated,
//   r_le=0, r_dout=0; then IDLE with req_ready=1 (back-to-back requests allowed;
//   new accept earliest the cycle after DONE).
//  Latency: accept -> rsp_valid = 1 + HALF_DIV*(1+2N) + 1 clk.
//   HALF_DIV=4: write 78 clk (no parity), read 86 clk.
//  req_valid while busy: ignored, no queueing; req_* may change freely.
//  r_reset asserted mid-transfer: outputs to reset values immediately, no
//   rsp_valid; partial CPLD state discarded (next transfer reloads fully).
//  HALF_DIV counter 8b, wraps only via explicit reload; pc never exceeds N.
// CONFIGURATION
//  TIPI_SHIFT_SEQ_PARITY_EN defined: writes add pulse 9 (r_le=0) after latch;
//   r_din sampled before pulse 10 is not used; instead r_din sampled in LO
//   phase after pulse 9 and compared to ^data; rsp_perr=1 on mismatch, set
//   with rsp_valid. Write N=10 (86 clk at HALF_DIV=4).
//  Not defined: writes N=9, rsp_perr tied 0, no parity logic synthesised.
// TESTING
//  1 reset with HALF_DIV=4 -> all outputs at reset values, r_clk=0 for 100 clk.
//  2 write RD 0xA5 -> r_rt=0,r_cd=1; r_dout seq 1,0,1,0,0,1,0,1 on rises 0..7,
//    r_le=1 only on pulse 8; CPLD model RD=0xA5; rsp_valid at accept+78 clk.
//  3 read TC, model TC=0x3C -> r_rt=1,r_cd=0, r_le on pulse 0 only, 10 pulses,
//    rsp_data=0x3C, rsp_valid at accept+86 clk.
//  4 r_reset low at pulse 4 of read TD -> r_clk=0,r_le=0 same cycle, no rsp;
//    following read TD 0x81 returns 0x81.
//  5 req_valid held with 2 queued-style changes while busy -> only first
//    accepted; back-to-back write RC 0xFF then read TD both complete correctly.
//  6 PARITY_EN: write RD 0x01, model parity forced wrong -> rsp_perr=1;
//    correct model -> rsp_perr=0; macro off -> rsp_perr=0, 9 pulses.

Source files
------------

// File: rtl/tipi_shift_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : tipi_shift_seq_if
// Request/response handshake between a requester and the TIPI link sequencer.
// Revision  : 1.0
// ============================================================================
interface tipi_shift_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_ctrl;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_perr;

  modport master (
    output req_valid, req_write, req_ctrl, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_perr
  );

  modport slave (
    input  req_valid, req_write, req_ctrl, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_perr
  );
endinterface
`default_nettype wire

// File: rtl/tipi_shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : tipi_shift_seq
// Pi-side TIPI serial register link sequencer (one byte per request).
// Option   : TIPI_SHIFT_SEQ_PARITY_EN adds a parity read-back pulse to writes.
// Revision : 1.0
// ============================================================================
module tipi_shift_seq #(
  parameter int unsigned HALF_DIV = 4
) (
  input  wire logic       clk,
  input  wire logic       r_reset,
  tipi_shift_seq_if.slave bus,
  output logic            r_clk,
  output logic            r_rt,
  output logic            r_cd,
  output logic            r_le,
  output logic            r_dout,
  input  wire logic       r_din
);

  localparam logic [7:0] DIV_LOAD = 8'(HALF_DIV - 1);
`ifdef TIPI_SHIFT_SEQ_PARITY_EN
  localparam logic [3:0] LAST_WR  = 4'd9;
`else
  localparam logic [3:0] LAST_WR  = 4'd8;
`endif
  localparam logic [3:0] LAST_RD  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_HI    = 3'd3,
    S_LO    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] div_cnt;
  logic [3:0] pc;
  logic [3:0] last_pc;
  logic       wr_q;
  logic [7:0] data_q;
  logic [7:0] shift_q;
  logic [3:0] pc_inc;

  assign pc_inc = pc + 4'd1;

  // Write latches on pulse 8; read parallel-loads on pulse 0.
  function automatic logic pulse_le(input logic wr, input logic [3:0] p);
    return wr ? (p == 4'd8) : (p == 4'd0);
  endfunction

  function automatic logic pulse_dout(input logic wr, input logic [7:0] d,
                                      input logic [3:0] p);
    return (wr && !p[3]) ? d[~p[2:0]] : 1'b0;
  endfunction

  always_ff @(posedge clk or negedge r_reset) begin
    if (!r_reset) begin
      state         <= S_IDLE;
      div_cnt       <= 8'd0;
      pc            <= 4'd0;
      last_pc       <= 4'd0;
      wr_q          <= 1'b0;
      data_q        <= 8'h00;
      shift_q       <= 8'h00;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 8'h00;
`ifdef TIPI_SHIFT_SEQ_PARITY_EN
      bus.rsp_perr  <= 1'b0;
`endif
      r_clk         <= 1'b0;
      r_rt          <= 1'b0;
      r_cd          <= 1'b1;
      r_le          <= 1'b0;
      r_dout        <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            wr_q          <= bus.req_write;
            data_q        <= bus.req_data;
            r_rt          <= ~bus.req_write;
            r_cd          <= ~bus.req_ctrl;
            last_pc       <= bus.req_write ? LAST_WR : LAST_RD;
            pc            <= 4'd0;
            bus.req_ready <= 1'b0;
            state         <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_le    <= pulse_le(wr_q, 4'd0);
          r_dout  <= pulse_dout(wr_q, data_q, 4'd0);
          div_cnt <= DIV_LOAD;
          state   <= S_SETUP;
        end

        S_SETUP: begin
          if (div_cnt == 8'd0) begin
            r_clk   <= 1'b1;
            div_cnt <= DIV_LOAD;
            state   <= S_HI;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        S_HI: begin
          if (div_cnt == 8'd0) begin
            r_clk   <= 1'b0;
            div_cnt <= DIV_LOAD;
            state   <= S_LO;
            // Next pulse's pins are set up while the clock is low.
            if (pc != last_pc) begin
              r_le   <= pulse_le(wr_q, pc_inc);
              r_dout <= pulse_dout(wr_q, data_q, pc_inc);
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        S_LO: begin
          if (div_cnt == 8'd0) begin
            // CPLD output is registered: bit for pulse k appears after rise k+1.
            if (!wr_q && (pc != 4'd0) && (pc <= 4'd8))
              shift_q <= {shift_q[6:0], r_din};
            pc <= pc_inc;
            if (pc == last_pc) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= wr_q ? 8'h00 : shift_q;
`ifdef TIPI_SHIFT_SEQ_PARITY_EN
              bus.rsp_perr  <= wr_q & (r_din ^ (^data_q));
`endif
              r_le          <= 1'b0;
              r_dout        <= 1'b0;
              state         <= S_DONE;
            end else begin
              r_clk   <= 1'b1;
              div_cnt <= DIV_LOAD;
              state   <= S_HI;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        S_DONE: begin
          bus.req_ready <= 1'b1;
          state         <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef TIPI_SHIFT_SEQ_PARITY_EN
  assign bus.rsp_perr = 1'b0;
`endif

endmodule
`default_nettype wire
